// File: rtl/ldl_p2ram_pkg.sv
// Shared types and the round-robin search helper for the RAM read-port arbiter.
package ldl_p2ram_pkg;

    // Upper bounds that size the generic picker; requester count must not exceed MAX_NR.
    localparam int MAX_NR = 32;
    localparam int MAX_IW = 5;

    // Result of a round-robin search: whether anyone was found, and who.
    typedef struct packed {
        logic              found;
        logic [MAX_IW-1:0] idx;
    } pick_t;

    // One-stage response pipeline entry: valid, requester index, bad-address flag.
    typedef struct packed {
        logic              vld;
        logic [MAX_IW-1:0] id;
        logic              bad;
    } rsp_t;

    // First set bit of valid at or after ptr, wrapping at nr. The search is
    // split into two straight passes (ptr..nr-1, then 0..ptr-1) so no modulo
    // hardware is needed.
    function automatic pick_t rr_pick(input logic [MAX_NR-1:0] valid,
                                      input int ptr,
                                      input int nr);
        pick_t r;
        r = '0;
        for (int i = 0; i < MAX_NR; i++) begin
            if (!r.found && i >= ptr && i < nr && valid[i]) begin
                r.found = 1'b1;
                r.idx   = MAX_IW'(i);
            end
        end
        for (int i = 0; i < MAX_NR; i++) begin
            if (!r.found && i < ptr && i < nr && valid[i]) begin
                r.found = 1'b1;
                r.idx   = MAX_IW'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ldl_rr_pick.sv
// Purely combinational round-robin priority picker; reusable for any NR up to MAX_NR.
module ldl_rr_pick
    import ldl_p2ram_pkg::*;
#(
    parameter int NR = 4,
    parameter int IW = $clog2(NR)
) (
    input  logic [NR-1:0] valid,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    pick_t pick;

    // Search from ptr upward with wrap-around and report the first requester found.
    always_comb begin
        pick  = rr_pick(MAX_NR'(valid), int'(ptr), NR);
        found = pick.found;
        idx   = IW'(pick.idx);
    end

endmodule

// File: rtl/ldl_p2ram_rd_arb.sv
// Round-robin arbiter for the read port of a simple dual-port RAM, with write
// snooping (reads that would race a same-address write are deferred), range
// checking, and a one-stage response return path.
module ldl_p2ram_rd_arb
    import ldl_p2ram_pkg::*;
#(
    parameter int NR    = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 10,
    parameter int AW    = $clog2(DEPTH),
    parameter int IW    = $clog2(NR),
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NR-1:0]    req_valid,
    input  logic [NR*AW-1:0] req_addr,
    output logic [NR-1:0]    req_ready,
    input  logic             wr_we,
    input  logic [AW-1:0]    wr_wa,
    output logic             ram_re,
    output logic [AW-1:0]    ram_ra,
    input  logic [DW-1:0]    ram_dout,
    input  logic             ram_rv,
    output logic [NR-1:0]    rsp_valid,
    output logic [DW-1:0]    rsp_data,
    output logic             rsp_err,
    output logic [CW-1:0]    coll_cnt
);

    // One extra bit so a power-of-two DEPTH still compares correctly.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] cand;
    logic [IW-1:0] next_ptr;
    logic          found;
    logic [AW-1:0] cand_addr;
    logic          in_range;
    logic          hit;
    logic          grant;
    rsp_t          p;

    ldl_rr_pick #(.NR(NR), .IW(IW)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (cand)
    );

    // A hit stalls the candidate without advancing the pointer, so it keeps
    // priority and nobody behind it can slip past while the write persists.
    // Out-of-range addresses never hit: they cannot alias a real RAM word.
    always_comb begin
        cand_addr = req_addr[cand*AW +: AW];
        in_range  = ({1'b0, cand_addr} < DEPTH_W);
        hit       = found & wr_we & (wr_wa == cand_addr) & in_range;
        grant     = found & ~hit & rst_n;
        next_ptr  = (cand == IW'(NR-1)) ? '0 : cand + 1'b1;
        req_ready = '0;
        if (grant) begin
            req_ready[cand] = 1'b1;
        end
        ram_re = grant & in_range;
        ram_ra = cand_addr;
    end

    // Round-robin pointer moves just past whoever was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= next_ptr;
        end
    end

    // Count deferred grants, sticking at the maximum instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_cnt <= '0;
        end else if (hit && coll_cnt != '1) begin
            coll_cnt <= coll_cnt + 1'b1;
        end
    end

    // Remember who was granted so the RAM result can be routed back next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else begin
            p <= '{vld: grant, id: MAX_IW'(cand), bad: ~in_range};
        end
    end

    // Response outputs; everything is gated by p.vld so idle and reset read as zero.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NR; i++) begin
            rsp_valid[i] = p.vld && (p.id == MAX_IW'(i));
        end
        rsp_err  = p.vld & (p.bad | ~ram_rv);
        rsp_data = (p.vld && !rsp_err) ? ram_dout : '0;
    end

    // A granted in-range read must always come back with the RAM's valid flag.
    a_rv_on_read: assert property (@(posedge clk) disable iff (!rst_n)
        (p.vld && !p.bad) |-> ram_rv);

endmodule

// File: tb/tb_ldl_p2ram_rd_arb.sv
// Directed testbench for ldl_p2ram_rd_arb with a scoreboard-driven response monitor.
module tb_ldl_p2ram_rd_arb;

    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 10;
    localparam int AW    = 4;
    localparam int CW    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]    req_ready;
    logic             wr_we;
    logic [AW-1:0]    wr_wa;
    logic [DW-1:0]    wr_wd;
    logic             ram_re;
    logic [AW-1:0]    ram_ra;
    logic [DW-1:0]    ram_dout = '0;
    logic             ram_rv = 1'b0;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             rsp_err;
    logic [CW-1:0]    coll_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    typedef struct {
        int            due;
        logic [NR-1:0] vld;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    // RAM word i starts as 0x30+i so expected read data is easy to hand-compute.
    logic [DW-1:0] mem [DEPTH] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34,
                                   8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    ldl_p2ram_rd_arb #(
        .NR(NR), .DW(DW), .DEPTH(DEPTH), .AW(AW), .CW(CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .wr_we     (wr_we),
        .wr_wa     (wr_wa),
        .ram_re    (ram_re),
        .ram_ra    (ram_ra),
        .ram_dout  (ram_dout),
        .ram_rv    (ram_rv),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .coll_cnt  (coll_cnt)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expected responses.
    always @(posedge clk) cyc <= cyc + 1;

    // Simple dual-port RAM model: registered read with a read-valid flag.
    always @(posedge clk) begin
        if (wr_we && wr_wa < AW'(DEPTH)) mem[wr_wa] <= wr_wd;
        if (ram_re) ram_dout <= mem[ram_ra];
        ram_rv <= ram_re;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [NR*AW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    // Drive a new input vector just after the rising edge.
    task automatic applyStimulus(input logic [NR-1:0] v, input logic [NR*AW-1:0] a,
                                 input logic we, input int wa, input logic [DW-1:0] wd);
        @(posedge clk);
        #1;
        req_valid = v;
        req_addr  = a;
        wr_we     = we;
        wr_wa     = AW'(wa);
        wr_wd     = wd;
    endtask

    // Check the request side mid-cycle and queue the response a grant should produce.
    task automatic checkOutput(input string name, input logic [NR-1:0] e_ready, input logic e_re,
                               input int e_ra, input logic [DW-1:0] e_data, input int e_cnt,
                               input bit e_rsp);
        @(negedge clk);
        check({name, ".ready"}, 32'(req_ready), 32'(e_ready));
        check({name, ".re"}, 32'(ram_re), 32'(e_re));
        if (e_re) check({name, ".ra"}, 32'(ram_ra), 32'(e_ra));
        check({name, ".cnt"}, 32'(coll_cnt), 32'(e_cnt));
        if (e_rsp && e_ready != '0)
            exp_q.push_back('{due: cyc + 1, vld: e_ready, err: !e_re, data: e_re ? e_data : '0});
    endtask

    // Response monitor: every cycle, rsp must match the queued expectation or be idle.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rsp.valid", 32'(rsp_valid), 32'(e.vld));
            check("rsp.err", 32'(rsp_err), 32'(e.err));
            check("rsp.data", 32'(rsp_data), 32'(e.data));
        end else begin
            check("rsp.idle", 32'(rsp_valid), 32'h0);
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_addr  = pack4(1, 2, 3, 4);
        wr_we     = 1'b0;
        wr_wa     = '0;
        wr_wd     = '0;

        // Reset state with all requesters asking: nothing may be granted.
        @(negedge clk);
        check("reset.ready", 32'(req_ready), 32'h0);
        check("reset.re", 32'(ram_re), 32'h0);
        check("reset.cnt", 32'(coll_cnt), 32'h0);
        check("reset.err", 32'(rsp_err), 32'h0);
        check("reset.data", 32'(rsp_data), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: four requesters served in order 0..3.
        checkOutput("t1.g0", 4'b0001, 1'b1, 1, 8'h31, 0, 1'b1);
        applyStimulus(4'b1110, pack4(1, 2, 3, 4), 1'b0, 0, 8'h00);
        checkOutput("t1.g1", 4'b0010, 1'b1, 2, 8'h32, 0, 1'b1);
        applyStimulus(4'b1100, pack4(1, 2, 3, 4), 1'b0, 0, 8'h00);
        checkOutput("t1.g2", 4'b0100, 1'b1, 3, 8'h33, 0, 1'b1);
        applyStimulus(4'b1000, pack4(1, 2, 3, 4), 1'b0, 0, 8'h00);
        checkOutput("t1.g3", 4'b1000, 1'b1, 4, 8'h34, 0, 1'b1);

        // 2: requester 2 collides with a 3-cycle write to addr 5; requester 3 must wait behind it.
        applyStimulus(4'b1100, pack4(0, 0, 5, 1), 1'b1, 5, 8'hA0);
        checkOutput("t2.c0", 4'b0000, 1'b0, 0, 8'h00, 0, 1'b1);
        applyStimulus(4'b1100, pack4(0, 0, 5, 1), 1'b1, 5, 8'hA1);
        checkOutput("t2.c1", 4'b0000, 1'b0, 0, 8'h00, 1, 1'b1);
        applyStimulus(4'b1100, pack4(0, 0, 5, 1), 1'b1, 5, 8'hA2);
        checkOutput("t2.c2", 4'b0000, 1'b0, 0, 8'h00, 2, 1'b1);
        applyStimulus(4'b1100, pack4(0, 0, 5, 1), 1'b0, 0, 8'h00);
        checkOutput("t2.g2", 4'b0100, 1'b1, 5, 8'hA2, 3, 1'b1);
        applyStimulus(4'b1000, pack4(0, 0, 5, 1), 1'b0, 0, 8'h00);
        checkOutput("t2.g3", 4'b1000, 1'b1, 1, 8'h31, 3, 1'b1);

        // 3: out-of-range address (== DEPTH) is granted without a RAM read; a write
        // to the same raw address must not be treated as a collision.
        applyStimulus(4'b0010, pack4(0, 10, 0, 0), 1'b1, 10, 8'h55);
        checkOutput("t3.oor", 4'b0010, 1'b0, 0, 8'h00, 3, 1'b1);

        // 4: move pointer to 3, then requesters 0 and 3 -> 3 first, then 0 (addr DEPTH-1).
        applyStimulus(4'b0100, pack4(0, 0, 0, 0), 1'b0, 0, 8'h00);
        checkOutput("t4.p2", 4'b0100, 1'b1, 0, 8'h30, 3, 1'b1);
        applyStimulus(4'b1001, pack4(9, 0, 0, 7), 1'b0, 0, 8'h00);
        checkOutput("t4.g3", 4'b1000, 1'b1, 7, 8'h37, 3, 1'b1);
        applyStimulus(4'b0001, pack4(9, 0, 0, 7), 1'b0, 0, 8'h00);
        checkOutput("t4.g0", 4'b0001, 1'b1, 9, 8'h39, 3, 1'b1);
        applyStimulus(4'b0011, pack4(9, 6, 0, 0), 1'b0, 0, 8'h00);
        checkOutput("t4.ptr1", 4'b0010, 1'b1, 6, 8'h36, 3, 1'b1);
        applyStimulus(4'b0000, pack4(0, 0, 0, 0), 1'b0, 0, 8'h00);
        checkOutput("t4.idle", 4'b0000, 1'b0, 0, 8'h00, 3, 1'b1);

        // 5: reset right after a grant discards the in-flight response.
        applyStimulus(4'b0001, pack4(2, 0, 0, 0), 1'b0, 0, 8'h00);
        checkOutput("t5.g0", 4'b0001, 1'b1, 2, 8'h32, 3, 1'b0);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_addr  = pack4(1, 2, 3, 4);
        checkOutput("t5.rst0", 4'b0000, 1'b0, 0, 8'h00, 0, 1'b0);
        checkOutput("t5.rst1", 4'b0000, 1'b0, 0, 8'h00, 0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("t5.ptr0", 4'b0001, 1'b1, 1, 8'h31, 0, 1'b1);
        applyStimulus(4'b0000, pack4(0, 0, 0, 0), 1'b0, 0, 8'h00);
        checkOutput("t5.idle", 4'b0000, 1'b0, 0, 8'h00, 0, 1'b1);

        // 6: five deferrals saturate the 2-bit counter at 3, then the stalled read is granted.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1000, pack4(0, 0, 0, 8), 1'b1, 8, DW'(8'hC0 + k));
            checkOutput("t6.coll", 4'b0000, 1'b0, 0, 8'h00, (k < 3) ? k : 3, 1'b1);
        end
        applyStimulus(4'b1000, pack4(0, 0, 0, 8), 1'b0, 0, 8'h00);
        checkOutput("t6.g3", 4'b1000, 1'b1, 8, 8'hC4, 3, 1'b1);
        applyStimulus(4'b0000, pack4(0, 0, 0, 0), 1'b0, 0, 8'h00);
        checkOutput("t6.idle", 4'b0000, 1'b0, 0, 8'h00, 3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard.empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
